// File: rtl/jump_pkg.sv
// jump_pkg: shared constants for the jump sequencer.
//   OP_*   : 3-bit sequencing op encoding presented on i_op
//   FLAG_* : default bit positions in the status-flag word
package jump_pkg;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_JMP  = 3'b001;
  localparam logic [2:0] OP_JC   = 3'b010;
  localparam logic [2:0] OP_CALL = 3'b011;
  localparam logic [2:0] OP_RET  = 3'b100;

  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_N = 2;

endpackage

// File: rtl/ret_stack.sv
// ret_stack: LIFO of return addresses.
//   clk, rst      : clock, synchronous active-high reset (clears count only)
//   push, pop     : push wins if both asserted; push-when-full and
//                   pop-when-empty are ignored
//   push_data     : value written on a push
//   top_data      : current top entry (meaningful only when !empty)
//   empty, full   : occupancy status
//   count         : number of valid entries
module ret_stack #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               push_data,
  output logic [W-1:0]               top_data,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]     mem [DEPTH];
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] top_cnt;
  logic             do_push;
  logic             do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == CNT_W'(DEPTH));
  assign count   = cnt;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty && !do_push;

  // Entry count-1 is the top; the write slot is entry count.
  assign top_cnt  = cnt - CNT_W'(1);
  assign top_data = mem[top_cnt[IDX_W-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (do_push) begin
      cnt <= cnt + CNT_W'(1);
    end else if (do_pop) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  // Storage is not reset; entries above count are never read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[cnt[IDX_W-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/jump_sequencer.sv
// jump_sequencer: program counter, status-flag register and return stack.
// Each enabled cycle one op (NOP/JMP/JC/CALL/RET) is evaluated and the PC
// updated; all outputs are registered.
//   i_clk, i_rst  : clock, synchronous active-high reset
//   i_en          : evaluate i_op this cycle
//   i_op          : sequencing op (jump_pkg::OP_*)
//   i_cond_sel    : flag index tested by JC (>= FLAG_W never taken)
//   i_cond_inv    : JC polarity, 1 = jump when flag clear
//   i_target      : jump / call destination
//   i_flag_we     : load i_flags into the flag register
//   i_flags       : new status flags
//   o_pc          : program counter
//   o_flags       : registered flags
//   o_jump        : one-cycle pulse when the last enabled op redirected PC
//   o_stack_empty : return stack empty
//   o_stack_full  : return stack full
//   o_fault       : sticky stack overflow/underflow, cleared by reset only
module jump_sequencer
  import jump_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int FLAG_W      = 3,
  parameter int STACK_DEPTH = 4
) (
  input  logic                                   i_clk,
  input  logic                                   i_rst,
  input  logic                                   i_en,
  input  logic [2:0]                             i_op,
  input  logic [((FLAG_W > 1) ? $clog2(FLAG_W) : 1)-1:0] i_cond_sel,
  input  logic                                   i_cond_inv,
  input  logic [ADDR_W-1:0]                      i_target,
  input  logic                                   i_flag_we,
  input  logic [FLAG_W-1:0]                      i_flags,
  output logic [ADDR_W-1:0]                      o_pc,
  output logic [FLAG_W-1:0]                      o_flags,
  output logic                                   o_jump,
  output logic                                   o_stack_empty,
  output logic                                   o_stack_full,
  output logic                                   o_fault
);

  localparam int CNT_W = $clog2(STACK_DEPTH + 1);

  // Wrapping increment used for both the step and the pushed return address.
  function automatic logic [ADDR_W-1:0] pc_wrap_inc(input logic [ADDR_W-1:0] pc);
    return pc + ADDR_W'(1);
  endfunction

  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] pc_nxt;
  logic              jump_nxt;
  logic              fault_set;
  logic              push;
  logic              pop;
  logic [ADDR_W-1:0] top_data;
  logic [CNT_W-1:0]  stack_count;
  logic              flag_bit;
  logic              cond_taken;

  ret_stack #(
    .W     (ADDR_W),
    .DEPTH (STACK_DEPTH)
  ) u_ret_stack (
    .clk       (i_clk),
    .rst       (i_rst),
    .push      (push),
    .pop       (pop),
    .push_data (pc_inc),
    .top_data  (top_data),
    .empty     (o_stack_empty),
    .full      (o_stack_full),
    .count     (stack_count)
  );

  assign pc_inc = pc_wrap_inc(o_pc);

  // Condition mux over the flag value held before this edge; an
  // out-of-range select yields "not taken" independent of polarity.
  always_comb begin
    flag_bit   = 1'b0;
    cond_taken = 1'b0;
    for (int i = 0; i < FLAG_W; i++) begin
      if (32'(i_cond_sel) == 32'(i)) begin
        flag_bit   = o_flags[i];
        cond_taken = flag_bit ^ i_cond_inv;
      end
    end
  end

  always_comb begin
    pc_nxt    = pc_inc;
    jump_nxt  = 1'b0;
    fault_set = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;
    if (i_en) begin
      case (i_op)
        OP_JMP: begin
          pc_nxt   = i_target;
          jump_nxt = 1'b1;
        end
        OP_JC: begin
          if (cond_taken) begin
            pc_nxt   = i_target;
            jump_nxt = 1'b1;
          end
        end
        OP_CALL: begin
          if (o_stack_full) begin
            fault_set = 1'b1;
          end else begin
            push     = 1'b1;
            pc_nxt   = i_target;
            jump_nxt = 1'b1;
          end
        end
        OP_RET: begin
          if (o_stack_empty) begin
            fault_set = 1'b1;
          end else begin
            pop      = 1'b1;
            pc_nxt   = top_data;
            jump_nxt = 1'b1;
          end
        end
        default: begin
          pc_nxt = pc_inc;
        end
      endcase
    end else begin
      pc_nxt = o_pc;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_pc    <= '0;
      o_flags <= '0;
      o_jump  <= 1'b0;
      o_fault <= 1'b0;
    end else begin
      o_pc   <= pc_nxt;
      o_jump <= jump_nxt;
      if (fault_set) begin
        o_fault <= 1'b1;
      end
      if (i_flag_we) begin
        o_flags <= i_flags;
      end
    end
  end

endmodule
